board_commit: RTL and testbench
===============================

Name: board_commit

Overview:
Writer side of the shared board bitmap. The rotation/move validity checks read this bitmap; this block writes it.
- When the active piece locks, it writes the piece's four cells into the board.
- It then scans for full rows, clears each one and shifts the rows above it down.
- It reports the number of lines cleared to the game controller and drives the board_memory bus read by the validity checkers and the VGA renderer.

Parameters:
COLS, 10, board width in cells
ROWS, 20, board height in cells; board_memory bit index = y*COLS + x, row 0 at top
CW, 10, coordinate width of cellX/cellY inputs

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
board_clear  input  1  synchronous new-game clear, highest priority
commit_valid  input  1  piece lock request; cell coords valid while high
commit_ready  output  1  high only in IDLE
cellX1..cellX4  input  CW each  column of each locked cell
cellY1..cellY4  input  CW each  row of each locked cell
board_memory  output  ROWS*COLS  registered board bitmap, [0:199] ordering
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse at end of commit
lines_cleared  output  3  full rows removed by last commit, 0..4, held until next done
overlap_err  output  1  sticky per commit: a target cell was already occupied
range_err  output  1  sticky per commit: a cell had x>=COLS or y>=ROWS

Behaviour:
Reset (rst_n low, asynchronous, any state):
- board_memory=0, lines_cleared=0, both err flags=0, done=0, state=IDLE.
- A reset in mid-commit discards the commit.

board_clear (checked every cycle, above everything else):
- Next edge: board=0, lines_cleared=0, flags=0, state=IDLE.
- An in-flight commit is dropped and no done is issued.

FSM states and transitions:
- IDLE: commit_ready=1. On commit_valid, latch the four coords, clear both err flags, go to WRITE.
- WRITE: one cycle.
  - In-range cells: OR-ed into the board.
  - Out-of-range cells: skipped, range_err set.
  - Any in-range cell already 1: overlap_err set; the cell is still written.
  - Load row pointer r=ROWS-1 and clear counter=0. Go to SCAN.
- SCAN: test row r, one row per cycle.
  - Row full (all COLS bits set): go to SHIFT.
  - Row not full and r==0: go to DONE.
  - Otherwise: r=r-1, stay in SCAN.
- SHIFT: one cycle.
  - Rows 0..r-1 copy into rows 1..r; row 0 becomes 0.
  - Clear counter increments, saturating at 7.
  - Return to SCAN with r unchanged, so the new content of row r is rescanned.
- DONE: one cycle. done=1, lines_cleared=counter. Return to IDLE.

Latency:
- Accept edge is cycle 0. WRITE is cycle 1, SCAN covers cycles 2..21, done is in cycle 22.
- Each cleared row adds 2 cycles, so done occurs at cycle 22+2k.

Boundary rules:
- commit_valid outside IDLE is ignored; the requester must hold it until it sees ready.
- Duplicate coordinates across the four cells are legal; the cell is written once.
- A full row 0 is cleared normally; row 0 is zero-filled.
- lines_cleared is 3 bits to flag illegal >4 results; the counter saturates at 7.

Optional Feature:
Macro BOARD_SCORE_EN.
- Defined:
  - Adds output score (16 bits), reset 0, cleared by board_clear.
  - In the DONE cycle, score += table[lines_cleared] with table 0/1/3/5/8 for 0..4 and 8 for >4; the add saturates at 16'hFFFF.
  - score updates on the same edge as the done pulse.
- Undefined: no score port, no adder; all other behaviour is identical.

Decomposition:
- Shared header global.v gains BOARD_COLS and BOARD_ROWS, the state encodings (IDLE, WRITE, SCAN, SHIFT, DONE), and the score table constants.
- One natural sub-module: board_row_full. It is purely combinational: it takes board_memory and row index r and returns the row-full bit. It is shared with the future preview logic.

Test Plan:
1. Empty board; commit I piece at (3..6,19) -> done at cycle 22, lines_cleared=0, bits 193..196 set, no errors.
2. Row 19 pre-filled except x=9 (via prior commits); commit vertical I at x=9, y=16..19 -> 1 line cleared, done at cycle 24, column 9 rows 17..19 =1, row 19 otherwise clear.
3. Rows 16..19 full except x=0; vertical I at x=0 -> lines_cleared=4, board all-zero, done at cycle 30; with BOARD_SCORE_EN score=8.
4. Commit a cell at x=10 -> range_err=1, other 3 cells written. Then commit onto an occupied cell -> overlap_err=1, cell remains 1.
5. board_clear during SCAN -> next cycle IDLE, board=0, no done pulse. rst_n low during SHIFT -> immediate zero outputs.
6. commit_valid held high through busy -> exactly one commit per IDLE visit, ready low from WRITE until return to IDLE.

Source files
------------

// File: rtl/board_commit_pkg.sv
// Shared board definitions: board geometry, FSM state encodings and line-clear score table.
// Latency: n/a (types, constants and one pure function only).
// Backpressure: n/a.
package board_commit_pkg;

    localparam int BOARD_COLS = 10;
    localparam int BOARD_ROWS = 20;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_SCAN  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Points awarded per commit, indexed by number of rows cleared.
    localparam logic [15:0] SCORE_L0 = 16'd0;
    localparam logic [15:0] SCORE_L1 = 16'd1;
    localparam logic [15:0] SCORE_L2 = 16'd3;
    localparam logic [15:0] SCORE_L3 = 16'd5;
    localparam logic [15:0] SCORE_L4 = 16'd8;

    // Counts above 4 cannot come from a legal piece; they earn the 4-line value.
    function automatic logic [15:0] score_pts(input logic [2:0] n);
        case (n)
            3'd0:    score_pts = SCORE_L0;
            3'd1:    score_pts = SCORE_L1;
            3'd2:    score_pts = SCORE_L2;
            3'd3:    score_pts = SCORE_L3;
            default: score_pts = SCORE_L4;
        endcase
    endfunction

endpackage

// File: rtl/board_row_full.sv
// Row-full detector: reports whether every cell of row row_i in the board bitmap is set.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
//
// Ports: board_i  - board bitmap, bit index y*COLS + x, row 0 at top
//        row_i    - row index to test (must be < ROWS)
//        full_o   - 1 when all COLS bits of that row are set
module board_row_full
    import board_commit_pkg::*;
#(
    parameter int COLS = BOARD_COLS,
    parameter int ROWS = BOARD_ROWS,
    parameter int RW   = $clog2(ROWS)
) (
    input  logic [0:ROWS*COLS-1] board_i,
    input  logic [RW-1:0]        row_i,
    output logic                 full_o
);

    localparam int IW = $clog2(ROWS*COLS);

    logic [IW-1:0] base;

    always_comb begin
        base   = IW'(int'(row_i) * COLS);
        full_o = 1'b1;
        for (int x = 0; x < COLS; x++) begin
            full_o = full_o & board_i[base + IW'(x)];
        end
    end

endmodule

// File: rtl/board_commit.sv
// Board writer: ORs a locked piece's four cells into the bitmap, then clears full rows and drops rows above.
// Latency: done pulses 22 + 2*k cycles after the accept edge (k = rows cleared).
// Backpressure: commit_ready is high only in IDLE; commit_valid seen in any other state is ignored.
//
// Ports: clk, rst_n (async active-low), board_clear (sync new-game clear, overrides everything)
//        commit_valid/commit_ready with cellX1..4/cellY1..4 - piece lock handshake and cell coordinates
//        board_memory - registered bitmap, bit y*COLS + x, row 0 at top
//        busy, done, lines_cleared, overlap_err, range_err - commit status
//        score - only when BOARD_SCORE_EN is defined: saturating 16-bit running score
module board_commit
    import board_commit_pkg::*;
#(
    parameter int COLS = BOARD_COLS,
    parameter int ROWS = BOARD_ROWS,
    parameter int CW   = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 board_clear,
    input  logic                 commit_valid,
    output logic                 commit_ready,
    input  logic [CW-1:0]        cellX1,
    input  logic [CW-1:0]        cellX2,
    input  logic [CW-1:0]        cellX3,
    input  logic [CW-1:0]        cellX4,
    input  logic [CW-1:0]        cellY1,
    input  logic [CW-1:0]        cellY2,
    input  logic [CW-1:0]        cellY3,
    input  logic [CW-1:0]        cellY4,
    output logic [0:ROWS*COLS-1] board_memory,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           lines_cleared,
    output logic                 overlap_err,
    output logic                 range_err
`ifdef BOARD_SCORE_EN
    ,
    output logic [15:0]          score
`endif
);

    localparam int RW = $clog2(ROWS);
    localparam int IW = $clog2(ROWS*COLS);
    localparam logic [CW-1:0] COLS_C = CW'(COLS);
    localparam logic [CW-1:0] ROWS_C = CW'(ROWS);

    state_e               state_q, state_d;
    logic [0:ROWS*COLS-1] board_q, board_d;
    logic [RW-1:0]        row_q, row_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [2:0]           lines_q, lines_d;
    logic                 ovl_q, ovl_d;
    logic                 rng_q, rng_d;
    logic [CW-1:0]        cx_q [4];
    logic [CW-1:0]        cx_d [4];
    logic [CW-1:0]        cy_q [4];
    logic [CW-1:0]        cy_d [4];
    logic [IW-1:0]        wr_idx;
    logic                 row_full;

`ifdef BOARD_SCORE_EN
    logic [15:0]          score_q, score_d;
    logic [16:0]          score_sum;
`endif

    board_row_full #(
        .COLS (COLS),
        .ROWS (ROWS),
        .RW   (RW)
    ) u_row_full (
        .board_i (board_q),
        .row_i   (row_q),
        .full_o  (row_full)
    );

    always_comb begin
        state_d = state_q;
        board_d = board_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        lines_d = lines_q;
        ovl_d   = ovl_q;
        rng_d   = rng_q;
        wr_idx  = '0;
        for (int i = 0; i < 4; i++) begin
            cx_d[i] = cx_q[i];
            cy_d[i] = cy_q[i];
        end
`ifdef BOARD_SCORE_EN
        score_d   = score_q;
        score_sum = {1'b0, score_q} + {1'b0, score_pts(cnt_q)};
`endif

        case (state_q)
            ST_IDLE: begin
                if (commit_valid) begin
                    cx_d[0] = cellX1;  cy_d[0] = cellY1;
                    cx_d[1] = cellX2;  cy_d[1] = cellY2;
                    cx_d[2] = cellX3;  cy_d[2] = cellY3;
                    cx_d[3] = cellX4;  cy_d[3] = cellY4;
                    ovl_d   = 1'b0;
                    rng_d   = 1'b0;
                    state_d = ST_WRITE;
                end
            end

            ST_WRITE: begin
                // Overlap is judged against the pre-commit board, so duplicate
                // coordinates inside one piece never flag each other.
                for (int i = 0; i < 4; i++) begin
                    if (cx_q[i] < COLS_C && cy_q[i] < ROWS_C) begin
                        wr_idx = IW'(int'(cy_q[i]) * COLS + int'(cx_q[i]));
                        if (board_q[wr_idx]) begin
                            ovl_d = 1'b1;
                        end
                        board_d[wr_idx] = 1'b1;
                    end else begin
                        rng_d = 1'b1;
                    end
                end
                row_d   = RW'(ROWS - 1);
                cnt_d   = 3'd0;
                state_d = ST_SCAN;
            end

            ST_SCAN: begin
                if (row_full) begin
                    state_d = ST_SHIFT;
                end else if (row_q == '0) begin
                    // Result and score are loaded on the edge that raises done,
                    // so both are already valid during the done cycle.
                    lines_d = cnt_q;
`ifdef BOARD_SCORE_EN
                    score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
`endif
                    state_d = ST_DONE;
                end else begin
                    row_d = row_q - RW'(1);
                end
            end

            ST_SHIFT: begin
                // Rows 0..r-1 drop one row; rows below r are untouched. Row
                // pointer is kept so the row that fell into r gets rescanned.
                for (int y = 1; y < ROWS; y++) begin
                    if (RW'(y) <= row_q) begin
                        for (int x = 0; x < COLS; x++) begin
                            board_d[IW'(y*COLS + x)] = board_q[IW'((y-1)*COLS + x)];
                        end
                    end
                end
                for (int x = 0; x < COLS; x++) begin
                    board_d[IW'(x)] = 1'b0;
                end
                cnt_d   = (cnt_q == 3'd7) ? 3'd7 : cnt_q + 3'd1;
                state_d = ST_SCAN;
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (board_clear) begin
            state_d = ST_IDLE;
            board_d = '0;
            cnt_d   = 3'd0;
            lines_d = 3'd0;
            ovl_d   = 1'b0;
            rng_d   = 1'b0;
`ifdef BOARD_SCORE_EN
            score_d = 16'd0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            board_q <= '0;
            row_q   <= '0;
            cnt_q   <= '0;
            lines_q <= '0;
            ovl_q   <= 1'b0;
            rng_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cx_q[i] <= '0;
                cy_q[i] <= '0;
            end
`ifdef BOARD_SCORE_EN
            score_q <= 16'd0;
`endif
        end else begin
            state_q <= state_d;
            board_q <= board_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            lines_q <= lines_d;
            ovl_q   <= ovl_d;
            rng_q   <= rng_d;
            for (int i = 0; i < 4; i++) begin
                cx_q[i] <= cx_d[i];
                cy_q[i] <= cy_d[i];
            end
`ifdef BOARD_SCORE_EN
            score_q <= score_d;
`endif
        end
    end

    assign commit_ready  = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign board_memory  = board_q;
    assign lines_cleared = lines_q;
    assign overlap_err   = ovl_q;
    assign range_err     = rng_q;
`ifdef BOARD_SCORE_EN
    assign score         = score_q;
`endif

endmodule

// File: tb/tb_board_commit.sv
`timescale 1ns/1ps
module tb_board_commit;

    localparam int COLS = 10;
    localparam int ROWS = 20;
    localparam int CW   = 10;
    localparam int N    = ROWS*COLS;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           board_clear = 1'b0;
    logic           commit_valid = 1'b0;
    logic           commit_ready;
    logic [CW-1:0]  cellX1 = '0, cellX2 = '0, cellX3 = '0, cellX4 = '0;
    logic [CW-1:0]  cellY1 = '0, cellY2 = '0, cellY3 = '0, cellY4 = '0;
    logic [0:N-1]   board_memory;
    logic           busy;
    logic           done;
    logic [2:0]     lines_cleared;
    logic           overlap_err;
    logic           range_err;
`ifdef BOARD_SCORE_EN
    logic [15:0]    score;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    board_commit #(.COLS(COLS), .ROWS(ROWS), .CW(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .board_clear   (board_clear),
        .commit_valid  (commit_valid),
        .commit_ready  (commit_ready),
        .cellX1        (cellX1),
        .cellX2        (cellX2),
        .cellX3        (cellX3),
        .cellX4        (cellX4),
        .cellY1        (cellY1),
        .cellY2        (cellY2),
        .cellY3        (cellY3),
        .cellY4        (cellY4),
        .board_memory  (board_memory),
        .busy          (busy),
        .done          (done),
        .lines_cleared (lines_cleared),
        .overlap_err   (overlap_err),
        .range_err     (range_err)
`ifdef BOARD_SCORE_EN
        ,
        .score         (score)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic int bi(input int x, input int y);
        return y*COLS + x;
    endfunction

    task automatic set_cells(input int x1, input int y1, input int x2, input int y2,
                             input int x3, input int y3, input int x4, input int y4);
        cellX1 = CW'(x1); cellY1 = CW'(y1);
        cellX2 = CW'(x2); cellY2 = CW'(y2);
        cellX3 = CW'(x3); cellY3 = CW'(y3);
        cellX4 = CW'(x4); cellY4 = CW'(y4);
    endtask

    task automatic wait_ready();
        for (int g = 0; g < 100 && !commit_ready; g++) @(negedge clk);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        board_clear = 1'b1;
        @(posedge clk); #1;
        board_clear = 1'b0;
        @(negedge clk);
    endtask

    // Returns with time at the negedge inside the done cycle; lat = cycle index of done
    // counting the accept edge as cycle 0 (so WRITE is cycle 1).
    task automatic commit4(input int x1, input int y1, input int x2, input int y2,
                           input int x3, input int y3, input int x4, input int y4,
                           output int lat);
        wait_ready();
        set_cells(x1, y1, x2, y2, x3, y3, x4, y4);
        commit_valid = 1'b1;
        @(posedge clk); #1;
        commit_valid = 1'b0;
        lat = 1;
        while (!done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!done) lat = -1;
        @(negedge clk);
    endtask

    task automatic fill_row_except(input int y, input int skip);
        int xs[$];
        int l;
        for (int x = 0; x < COLS; x++) if (x != skip) xs.push_back(x);
        while (xs.size() % 4 != 0) xs.push_back(xs[xs.size()-1]);
        for (int i = 0; i < xs.size(); i += 4)
            commit4(xs[i], y, xs[i+1], y, xs[i+2], y, xs[i+3], y, l);
    endtask

    task automatic test_reset();
        logic [0:N-1] zero;
        zero = '0;
        rst_n = 1'b0;
        #12;
        n_cmp++; if (board_memory !== zero) begin n_bad++; $display("FAIL reset_board: got %h want 0", board_memory); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (lines_cleared !== 3'd0) begin n_bad++; $display("FAIL reset_lines: got %0d want 0", lines_cleared); end
        n_cmp++; if ({overlap_err, range_err} !== 2'b00) begin n_bad++; $display("FAIL reset_errs: got %b want 00", {overlap_err, range_err}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (commit_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", commit_ready); end
`ifdef BOARD_SCORE_EN
        n_cmp++; if (score !== 16'd0) begin n_bad++; $display("FAIL reset_score: got %0d want 0", score); end
`endif
    endtask

    task automatic test_place();
        logic [0:N-1] exp;
        int lat;
        exp = '0;
        for (int x = 3; x <= 6; x++) exp[bi(x, 19)] = 1'b1;
        commit4(3, 19, 4, 19, 5, 19, 6, 19, lat);
        n_cmp++; if (lat !== 22) begin n_bad++; $display("FAIL place_latency: got %0d want 22", lat); end
        n_cmp++; if (lines_cleared !== 3'd0) begin n_bad++; $display("FAIL place_lines: got %0d want 0", lines_cleared); end
        n_cmp++; if (board_memory !== exp) begin n_bad++; $display("FAIL place_board: got %h want %h", board_memory, exp); end
        n_cmp++; if ({overlap_err, range_err} !== 2'b00) begin n_bad++; $display("FAIL place_errs: got %b want 00", {overlap_err, range_err}); end
    endtask

    task automatic test_single_clear();
        logic [0:N-1] exp;
        int lat;
        pulse_clear();
        fill_row_except(19, 9);
        commit4(9, 16, 9, 17, 9, 18, 9, 19, lat);
        exp = '0;
        exp[bi(9, 17)] = 1'b1;
        exp[bi(9, 18)] = 1'b1;
        exp[bi(9, 19)] = 1'b1;
        n_cmp++; if (lat !== 24) begin n_bad++; $display("FAIL single_latency: got %0d want 24", lat); end
        n_cmp++; if (lines_cleared !== 3'd1) begin n_bad++; $display("FAIL single_lines: got %0d want 1", lines_cleared); end
        n_cmp++; if (board_memory !== exp) begin n_bad++; $display("FAIL single_board: got %h want %h", board_memory, exp); end
`ifdef BOARD_SCORE_EN
        n_cmp++; if (score !== 16'd1) begin n_bad++; $display("FAIL single_score: got %0d want 1", score); end
`endif
    endtask

    task automatic test_quad_clear();
        logic [0:N-1] zero;
        int lat;
        zero = '0;
        pulse_clear();
        for (int y = 16; y <= 19; y++) fill_row_except(y, 0);
        commit4(0, 16, 0, 17, 0, 18, 0, 19, lat);
        n_cmp++; if (lat !== 30) begin n_bad++; $display("FAIL quad_latency: got %0d want 30", lat); end
        n_cmp++; if (lines_cleared !== 3'd4) begin n_bad++; $display("FAIL quad_lines: got %0d want 4", lines_cleared); end
        n_cmp++; if (board_memory !== zero) begin n_bad++; $display("FAIL quad_board: got %h want 0", board_memory); end
`ifdef BOARD_SCORE_EN
        n_cmp++; if (score !== 16'd8) begin n_bad++; $display("FAIL quad_score: got %0d want 8", score); end
`endif
    endtask

    task automatic test_clear_abort();
        logic [0:N-1] zero;
        int seen;
        zero = '0;
        wait_ready();
        set_cells(10, 0, 0, 0, 1, 0, 2, 0);
        commit_valid = 1'b1;
        @(posedge clk); #1;
        commit_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL abort_busy_before: got %b want 1", busy); end
        board_clear = 1'b1;
        @(posedge clk); #1;
        board_clear = 1'b0;
        n_cmp++; if (commit_ready !== 1'b1) begin n_bad++; $display("FAIL abort_ready: got %b want 1", commit_ready); end
        n_cmp++; if (board_memory !== zero) begin n_bad++; $display("FAIL abort_board: got %h want 0", board_memory); end
        n_cmp++; if (lines_cleared !== 3'd0) begin n_bad++; $display("FAIL abort_lines: got %0d want 0", lines_cleared); end
        n_cmp++; if (range_err !== 1'b0) begin n_bad++; $display("FAIL abort_range: got %b want 0", range_err); end
`ifdef BOARD_SCORE_EN
        n_cmp++; if (score !== 16'd0) begin n_bad++; $display("FAIL abort_score: got %0d want 0", score); end
`endif
        seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d pulses want 0", seen); end
        @(negedge clk);
    endtask

    task automatic test_errors();
        logic [0:N-1] exp;
        int lat;
        pulse_clear();
        exp = '0;
        commit4(10, 5, 0, 0, 1, 0, 2, 0, lat);
        exp[bi(0, 0)] = 1'b1; exp[bi(1, 0)] = 1'b1; exp[bi(2, 0)] = 1'b1;
        n_cmp++; if (range_err !== 1'b1) begin n_bad++; $display("FAIL range_flag: got %b want 1", range_err); end
        n_cmp++; if (overlap_err !== 1'b0) begin n_bad++; $display("FAIL range_no_ovl: got %b want 0", overlap_err); end
        n_cmp++; if (board_memory !== exp) begin n_bad++; $display("FAIL range_board: got %h want %h", board_memory, exp); end
        commit4(1, 0, 5, 5, 5, 5, 6, 5, lat);
        exp[bi(5, 5)] = 1'b1; exp[bi(6, 5)] = 1'b1;
        n_cmp++; if (overlap_err !== 1'b1) begin n_bad++; $display("FAIL ovl_flag: got %b want 1", overlap_err); end
        n_cmp++; if (range_err !== 1'b0) begin n_bad++; $display("FAIL ovl_range_cleared: got %b want 0", range_err); end
        n_cmp++; if (board_memory !== exp) begin n_bad++; $display("FAIL ovl_board: got %h want %h", board_memory, exp); end
        commit4(7, 7, 7, 7, 7, 7, 7, 7, lat);
        exp[bi(7, 7)] = 1'b1;
        n_cmp++; if ({overlap_err, range_err} !== 2'b00) begin n_bad++; $display("FAIL dup_errs: got %b want 00", {overlap_err, range_err}); end
        n_cmp++; if (board_memory !== exp) begin n_bad++; $display("FAIL dup_board: got %h want %h", board_memory, exp); end
        n_cmp++; if (lat !== 22) begin n_bad++; $display("FAIL dup_latency: got %0d want 22", lat); end
    endtask

    task automatic test_reset_mid();
        logic [0:N-1] zero;
        zero = '0;
        pulse_clear();
        fill_row_except(19, 9);
        wait_ready();
        set_cells(9, 16, 9, 17, 9, 18, 9, 19);
        commit_valid = 1'b1;
        @(posedge clk); #1;
        commit_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy: got %b want 1", busy); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (board_memory !== zero) begin n_bad++; $display("FAIL rstmid_board: got %h want 0", board_memory); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy_after: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rstmid_done: got %b want 0", done); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (commit_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready: got %b want 1", commit_ready); end
    endtask

    task automatic test_back_to_back();
        logic [0:N-1] exp;
        logic exp_rdy;
        logic exp_done;
        pulse_clear();
        set_cells(0, 0, 1, 0, 2, 0, 3, 0);
        commit_valid = 1'b1;
        for (int c = 1; c <= 46; c++) begin
            @(posedge clk); #1;
            exp_rdy  = (c == 23) || (c == 46);
            exp_done = (c == 22) || (c == 45);
            n_cmp++; if (commit_ready !== exp_rdy) begin n_bad++; $display("FAIL b2b_ready c=%0d: got %b want %b", c, commit_ready, exp_rdy); end
            n_cmp++; if (done !== exp_done) begin n_bad++; $display("FAIL b2b_done c=%0d: got %b want %b", c, done, exp_done); end
            n_cmp++; if (busy !== !exp_rdy) begin n_bad++; $display("FAIL b2b_busy c=%0d: got %b want %b", c, busy, !exp_rdy); end
        end
        commit_valid = 1'b0;
        exp = '0;
        for (int x = 0; x < 4; x++) exp[bi(x, 0)] = 1'b1;
        n_cmp++; if (overlap_err !== 1'b1) begin n_bad++; $display("FAIL b2b_ovl: got %b want 1", overlap_err); end
        n_cmp++; if (board_memory !== exp) begin n_bad++; $display("FAIL b2b_board: got %h want %h", board_memory, exp); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_place();
        test_single_clear();
        test_quad_clear();
        test_clear_abort();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
